// File: rtl/hs_unit_rr_arb_slice.sv
// Round-robin N-to-1 arbiter into a single registered output slot.
// Carries the winning requester index alongside the payload.
module hs_unit_rr_arb_slice #(
  parameter type DATA_TYPE = logic [31:0],
  parameter DATA_TYPE RESET_VALUE = '0,
  parameter int NUM_REQ = 4,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic [NUM_REQ-1:0] req_valid,
  input  DATA_TYPE           req_data [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
  output logic               out_valid,
  output DATA_TYPE           out_data,
  output logic [ID_W-1:0]    out_id,
  input  logic               out_ready
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   gidx;
  logic [ID_W-1:0]   ptr_nxt;
  logic [NUM_REQ-1:0] gnt;
  logic              found;
  logic              load_en;
  logic              xfer;

  // Scan distances from ptr; the nearest valid requester wins.
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] &&
            ((int'(ptr) + k) % NUM_REQ) == i) begin
          found  = 1'b1;
          gidx   = ID_W'(i);
          gnt[i] = 1'b1;
        end
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign load_en   = !out_valid || out_ready;
  assign req_ready = load_en ? gnt : '0;
  assign xfer      = load_en && found;
  assign ptr_nxt   = (gidx == ID_W'(NUM_REQ - 1))
                   ? '0 : gidx + 1'b1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (found) state_d = FULL;
      FULL:  if (out_ready && !found) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_data <= RESET_VALUE;
      out_id   <= '0;
      ptr      <= '0;
    end else if (xfer) begin
      out_data <= req_data[gidx];
      out_id   <= gidx;
      ptr      <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_hs_unit_rr_arb_slice.sv
// Randomized self-checking bench for hs_unit_rr_arb_slice.
// Covers a 4-requester build and a single-requester build.
module tb_hs_unit_rr_arb_slice;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;

  logic [3:0]  rv4 = '0;
  logic [3:0]  rr4;
  logic [31:0] rd4 [4];
  logic        ov4;
  logic [31:0] od4;
  logic [1:0]  oid4;
  logic        ordy4 = 1'b0;

  logic [0:0]  rv1 = '0;
  logic [0:0]  rr1;
  logic [31:0] rd1 [1];
  logic        ov1;
  logic [31:0] od1;
  logic [0:0]  oid1;
  logic        ordy1 = 1'b0;

  int n_run = 0;
  int n_fail = 0;

  int          m_ptr;
  logic        m_valid;
  logic [31:0] m_data;
  int          m_id;

  always #5 clk = ~clk;

  hs_unit_rr_arb_slice #(.NUM_REQ(4)) u4 (
    .clk(clk), .aresetn(aresetn),
    .req_valid(rv4), .req_data(rd4), .req_ready(rr4),
    .out_valid(ov4), .out_data(od4), .out_id(oid4),
    .out_ready(ordy4)
  );

  hs_unit_rr_arb_slice #(.NUM_REQ(1)) u1 (
    .clk(clk), .aresetn(aresetn),
    .req_valid(rv1), .req_data(rd1), .req_ready(rr1),
    .out_valid(ov1), .out_data(od1), .out_id(oid1),
    .out_ready(ordy1)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int ref_grant(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_id = 0;
  endtask

  task automatic do_reset();
    rv4 = '0; rv1 = '0;
    @(negedge clk) aresetn = 1'b0;
    @(negedge clk) aresetn = 1'b1;
    model_reset();
  endtask

  // One cycle of the 4-way build; g returns the transferred id or -1.
  task automatic cyc4(input logic [3:0] v, input logic r,
                      output int g,
                      output logic [3:0] rdy_obs,
                      output logic [3:0] rdy_exp,
                      output logic [34:0] o_obs,
                      output logic [34:0] o_exp);
    logic load;
    rv4 = v; ordy4 = r;
    #1;
    g = ref_grant(v, m_ptr);
    load = !m_valid || r;
    rdy_exp = '0;
    if (load && g >= 0) rdy_exp[g] = 1'b1;
    rdy_obs = rr4;
    @(posedge clk);
    if (load) begin
      if (g >= 0) begin
        m_valid = 1'b1; m_data = rd4[g];
        m_id = g; m_ptr = (g + 1) % 4;
      end else begin
        m_valid = 1'b0;
      end
    end else begin
      g = -1;
    end
    @(negedge clk);
    o_obs = {ov4, oid4, od4};
    o_exp = {m_valid, 2'(m_id), m_data};
  endtask

  task automatic test_reset();
    int g;
    logic [3:0] ro, re;
    logic [34:0] oo, oe;
    repeat (2) @(negedge clk);
    n_run++;
    if ({ov4, oid4, od4} !== 35'd0 || rr4 !== 4'd0) begin
      $display("FAIL reset4 got %b/%h exp 0", ov4, od4); n_fail++;
    end
    n_run++;
    if ({ov1, oid1, od1} !== 34'd0 || rr1 !== 1'b0) begin
      $display("FAIL reset1 got %b/%h exp 0", ov1, od1); n_fail++;
    end
    aresetn = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) rd4[i] = 32'hA0 + i;
    repeat (3) cyc4(4'hF, 1'b0, g, ro, re, oo, oe);
    n_run++;
    if (oo !== oe || ov4 !== 1'b1) begin
      $display("FAIL prefill got %h exp %h", oo, oe); n_fail++;
    end
    #2 aresetn = 1'b0;
    #1;
    n_run++;
    if ({ov4, oid4, od4} !== 35'd0) begin
      $display("FAIL async_reset got %h exp 0", {ov4, oid4, od4});
      n_fail++;
    end
    rv4 = '0;
    #1;
    n_run++;
    if (rr4 !== 4'd0) begin
      $display("FAIL reset_ready got %b exp 0", rr4); n_fail++;
    end
    @(negedge clk) aresetn = 1'b1;
    model_reset();
  endtask

  task automatic test_round_robin();
    int g;
    logic [3:0] ro, re;
    logic [34:0] oo, oe;
    for (int k = 0; k < 8; k++) begin
      cyc4(4'hF, 1'b1, g, ro, re, oo, oe);
      n_run++;
      if (g != k % 4 || ro !== re) begin
        $display("FAIL rr_grant k=%0d got %0d/%b exp %0d/%b",
                 k, g, ro, k % 4, re);
        n_fail++;
      end
      n_run++;
      if (oo !== oe || oid4 !== 2'(k % 4) ||
          od4 !== 32'hA0 + 32'(k % 4)) begin
        $display("FAIL rr_out k=%0d got %h exp %h", k, oo, oe);
        n_fail++;
      end
    end
  endtask

  task automatic test_stall();
    int g;
    logic [3:0] ro, re;
    logic [34:0] oo, oe;
    do_reset();
    cyc4(4'b0010, 1'b1, g, ro, re, oo, oe);
    n_run++;
    if (oid4 !== 2'd1 || ov4 !== 1'b1) begin
      $display("FAIL stall_fill got id %0d exp 1", oid4); n_fail++;
    end
    for (int k = 0; k < 5; k++) begin
      cyc4(4'hF, 1'b0, g, ro, re, oo, oe);
      n_run++;
      if (ro !== 4'd0 || oo !== {1'b1, 2'd1, 32'hA1}) begin
        $display("FAIL stall_hold k=%0d got %b/%h exp 0/%h",
                 k, ro, oo, {1'b1, 2'd1, 32'hA1});
        n_fail++;
      end
    end
    cyc4(4'hF, 1'b1, g, ro, re, oo, oe);
    n_run++;
    if (g != 2 || oid4 !== 2'd2 || ro !== 4'b0100) begin
      $display("FAIL stall_release got %0d/%b exp 2/0100", g, ro);
      n_fail++;
    end
  endtask

  task automatic test_wrap();
    int g;
    logic [3:0] ro, re;
    logic [34:0] oo, oe;
    do_reset();
    cyc4(4'b0100, 1'b1, g, ro, re, oo, oe);
    for (int k = 0; k < 3; k++) begin
      cyc4(4'b0101, 1'b1, g, ro, re, oo, oe);
      n_run++;
      if (g != ((k % 2) ? 2 : 0) || oo !== oe) begin
        $display("FAIL wrap k=%0d got %0d exp %0d",
                 k, g, (k % 2) ? 2 : 0);
        n_fail++;
      end
    end
  endtask

  task automatic test_no_bubble();
    int g;
    logic [3:0] ro, re;
    logic [34:0] oo, oe;
    for (int k = 0; k < 4; k++) begin
      rd4[1] = $urandom;
      cyc4(4'b0010, 1'b1, g, ro, re, oo, oe);
      n_run++;
      if (ov4 !== 1'b1 || oid4 !== 2'd1 || od4 !== rd4[1]) begin
        $display("FAIL no_bubble k=%0d got %b/%h exp 1/%h",
                 k, ov4, od4, rd4[1]);
        n_fail++;
      end
    end
  endtask

  task automatic test_random4();
    int g;
    logic [3:0] ro, re, pend;
    logic [34:0] oo, oe;
    int bad = 0;
    do_reset();
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom % 2 == 1)) begin
          pend[i] = 1'b1; rd4[i] = $urandom;
        end
      end
      cyc4(pend, ($urandom % 4) != 0, g, ro, re, oo, oe);
      if (g >= 0) pend[g] = 1'b0;
      n_run++;
      if (ro !== re || oo !== oe) begin
        if (bad < 5)
          $display("FAIL random4 c=%0d got %b/%h exp %b/%h",
                   c, ro, oo, re, oe);
        bad++; n_fail++;
      end
    end
  endtask

  task automatic test_single();
    logic [31:0] q [$];
    logic [31:0] exp_d;
    logic xin, xout, er;
    int bad = 0;
    do_reset();
    for (int c = 0; c < 420; c++) begin
      if (c < 400 && !rv1[0] && ($urandom % 2 == 1)) begin
        rv1 = 1'b1; rd1[0] = $urandom;
      end
      ordy1 = (c >= 400) || ($urandom % 3 != 0);
      #1;
      er = rv1[0] && (!ov1 || ordy1);
      xin = rv1[0] && rr1[0];
      xout = ov1 && ordy1;
      n_run++;
      if (rr1[0] !== er || (ov1 && (oid1 !== 1'b0 || q.size() == 0))) begin
        if (bad < 5)
          $display("FAIL single_ctl c=%0d got rdy %b id %b q %0d exp rdy %b",
                   c, rr1, oid1, q.size(), er);
        bad++; n_fail++;
      end
      if (xout && q.size() > 0) begin
        exp_d = q.pop_front();
        n_run++;
        if (od1 !== exp_d) begin
          if (bad < 5)
            $display("FAIL single_data c=%0d got %h exp %h", c, od1, exp_d);
          bad++; n_fail++;
        end
      end
      @(posedge clk);
      if (xin) q.push_back(rd1[0]);
      @(negedge clk);
      if (xin) rv1 = 1'b0;
    end
    n_run++;
    if (q.size() != 0 || ov1 !== 1'b0) begin
      $display("FAIL single_drain got %0d left exp 0", q.size());
      n_fail++;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rd4[i] = '0;
    rd1[0] = '0;
    model_reset();
    test_reset();
    test_round_robin();
    test_stall();
    test_wrap();
    test_no_bubble();
    test_random4();
    test_single();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
